cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Round-robin arbiter sharing `CDB_PORTS` common-data-bus broadcast slots among `FU_NUM` functional units in the Tomasulo core. Each FU holds a finished result, tagged with its reorder-buffer index, until it is granted. Granted results are registered onto the CDB slot outputs. The downstream CDB data controller samples those outputs on the following negative clock edge.

## Interface
Parameters:
- `FU_NUM`, 6, number of requesting functional units
- `CDB_PORTS`, 2, broadcast slots per cycle (1..`FU_NUM`)
- `WORD_SIZE`, 32, result width
- `RB_INDEX`, 4, reorder-buffer index width; all-ones is the `NULL` index

Ports:
- `clk`  in  1  system clock, posedge
- `reset`  in  1  reset, asynchronous, active-high
- `flush`  in  1  mispredict flush, synchronous; drops in-flight broadcast
- `fu_req`  in  `FU_NUM`  per-FU result-pending request
- `fu_data`  in  `WORD_SIZE*FU_NUM`  per-FU result, FU i at bits [i*WORD_SIZE +: WORD_SIZE]
- `fu_index`  in  `RB_INDEX*FU_NUM`  per-FU destination RB index
- `fu_grant`  out  `FU_NUM`  combinational grant; req&grant at posedge = transfer
- `cdb_valid`  out  `CDB_PORTS`  slot k carries a result
- `cdb_data`  out  `WORD_SIZE*CDB_PORTS`  slot results
- `cdb_index`  out  `RB_INDEX*CDB_PORTS`  slot RB indices; `NULL` when slot invalid

## Operation
- Eligible FU: `fu_req[i]`=1 and `fu_index` slice ≠ `NULL`. Requests carrying `NULL` are never granted and never counted.
- State: round-robin pointer `rr_ptr` (0..`FU_NUM`-1) and the registered slot outputs.
- Each cycle the arbiter scans eligible FUs cyclically from `rr_ptr`. The first `CDB_PORTS` found are granted; the j-th grant maps to slot j.
- `fu_grant` is a pure function of `fu_req`, `fu_index`, `rr_ptr` and `flush`. At most `CDB_PORTS` bits are set.
- At posedge, for each slot j:
  - If granted: `cdb_valid[j]`=1 and data/index are copied from the granted FU.
  - Otherwise: `cdb_valid[j]`=0 and `cdb_index` slot = `NULL`; `cdb_data` slot holds its last value.
- Pointer update:
  - With ≥1 grant: `rr_ptr` becomes (last granted FU + 1) mod `FU_NUM`.
  - With no grants: `rr_ptr` holds.
- Starvation bound: an eligible FU that keeps its request asserted is granted within ceil(`FU_NUM`/`CDB_PORTS`) cycles.
- FU contract: an FU keeps `fu_req`, data and index stable until it sees a grant, and may drop the request only after the transfer.
- `flush`=1:
  - `fu_grant` is forced to 0.
  - At posedge, all `cdb_valid` clear and all `cdb_index` slots become `NULL`.
  - `rr_ptr` holds.
  - FUs are flushed by their own logic.
- `reset`:
  - Immediately sets `cdb_valid`=0, `cdb_data`=0, all `cdb_index`=`NULL`, `rr_ptr`=0, and stats=0.
  - `fu_grant` is 0 while `reset` is high.
  - An in-flight broadcast is discarded.

## Timing
- Grant: same cycle as request, combinational.
- Broadcast: `cdb_*` is valid 1 cycle after the transfer edge and is held for exactly one cycle unless a new grant replaces it.
- Back-to-back: an FU may be granted on consecutive cycles if its request is re-asserted and no other eligible FU precedes it in scan order.
- `FU_NUM`=`CDB_PORTS`: every eligible request is granted immediately.
- Pointer wrap: if the last grant is FU `FU_NUM`-1, `rr_ptr` becomes 0.

## Configuration
- `CDB_ARB_STATS_EN` defined adds two outputs:
  - `stat_conflicts` (32 bits): counts cycles in which eligible requests exceed `CDB_PORTS`.
  - `stat_broadcasts` (32 bits): counts granted results.
  - Both saturate at all-ones, clear on `reset`, and are unaffected by `flush`.
- Undefined: the two ports and their counters are absent. All other behaviour is identical.

## Structure
- Shared package `cdb_pkg` holds `WORD_SIZE`, `RB_INDEX`, `NULL` and `FU_NUM` defaults, shared with the CDB data controller and reservation stations.
- One sub-module, `cdb_rr_picker`: combinational cyclic find-first-N from a start pointer. Outputs the grant vector, per-slot FU number, and last granted FU.

## Test plan
- Reset: assert `reset` mid-broadcast → `cdb_valid`=00, `cdb_index`={F,F}, `fu_grant`=0 immediately; after release `rr_ptr`=0.
- All six FUs request (indices 0..5), `CDB_PORTS`=2:
  - Cycle 1 grants FU0,FU1; cycle 2 grants FU2,FU3; cycle 3 grants FU4,FU5.
  - `cdb_index`={0,1},{2,3},{4,5} one cycle after each grant.
- FU3 requests with index 4'hF, FU5 requests with index 7 → only FU5 granted; slot0 index=7, data matches, `cdb_valid`=01.
- Wrap: `rr_ptr`=5; FU5 and FU0 request → FU5 to slot0, FU0 to slot1; `rr_ptr` becomes 1.
- `flush` with FU1,FU2 requesting → `fu_grant`=0; `cdb_valid`=00 next cycle; `rr_ptr` unchanged; next cycle FU1 and FU2 are granted.
- `CDB_ARB_STATS_EN`: 3 cycles of 4 eligible requests → `stat_conflicts`=3, `stat_broadcasts`=6.

Source files
------------

// File: rtl/cdb_pkg.sv
// Shared CDB definitions: default widths, FU count and the NULL reorder-buffer index.
// Used by the arbiter, the CDB data controller and the reservation stations.
package cdb_pkg;

    localparam int WORD_SIZE = 32;
    localparam int RB_INDEX  = 4;
    localparam int FU_NUM    = 6;
    localparam int CDB_PORTS = 2;

    localparam logic [RB_INDEX-1:0] NULL = '1;

    // Pointer width that stays legal for a single-entry range.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cdb_rr_picker.sv
// Cyclic find-first-P over N eligible bits starting at i_start.
// The j-th hit goes to slot j; o_last_fu is the final hit in scan order.
module cdb_rr_picker
    import cdb_pkg::*;
#(
    parameter int N  = 6,
    parameter int P  = 2,
    parameter int PW = ptr_width(N)
) (
    input  logic [N-1:0]          i_elig,
    input  logic [PW-1:0]         i_start,
    output logic [N-1:0]          o_grant,
    output logic [P-1:0][PW-1:0]  o_slot_fu,
    output logic [P-1:0]          o_slot_vld,
    output logic [PW-1:0]         o_last_fu,
    output logic                  o_any
);

    always_comb begin
        int found;
        int idx;
        o_grant    = '0;
        o_slot_fu  = '0;
        o_slot_vld = '0;
        o_last_fu  = '0;
        found      = 0;
        idx        = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(i_start) + k;
            if (idx >= N) idx = idx - N;
            if (i_elig[idx] && (found < P)) begin
                o_grant[idx]      = 1'b1;
                o_slot_fu[found]  = PW'(idx);
                o_slot_vld[found] = 1'b1;
                o_last_fu         = PW'(idx);
                found             = found + 1;
            end
        end
    end

    assign o_any = |o_grant;

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing CDB_PORTS broadcast slots among FU_NUM functional units.
// Define CDB_ARB_STATS_EN to add the saturating stat_conflicts / stat_broadcasts counters.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int FU_NUM    = cdb_pkg::FU_NUM,
    parameter int CDB_PORTS = cdb_pkg::CDB_PORTS,
    parameter int WORD_SIZE = cdb_pkg::WORD_SIZE,
    parameter int RB_INDEX  = cdb_pkg::RB_INDEX
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic [FU_NUM-1:0]             fu_req,
    input  logic [WORD_SIZE*FU_NUM-1:0]   fu_data,
    input  logic [RB_INDEX*FU_NUM-1:0]    fu_index,
    output logic [FU_NUM-1:0]             fu_grant,
    output logic [CDB_PORTS-1:0]          cdb_valid,
    output logic [WORD_SIZE*CDB_PORTS-1:0] cdb_data,
    output logic [RB_INDEX*CDB_PORTS-1:0] cdb_index
`ifdef CDB_ARB_STATS_EN
    ,
    output logic [31:0]                   stat_conflicts,
    output logic [31:0]                   stat_broadcasts
`endif
);

    localparam int PW = ptr_width(FU_NUM);
    localparam logic [RB_INDEX-1:0] RB_NULL = {RB_INDEX{1'b1}};

    logic [PW-1:0]                 r_rr_ptr;
    logic [CDB_PORTS-1:0]          r_cdb_valid;
    logic [WORD_SIZE*CDB_PORTS-1:0] r_cdb_data;
    logic [RB_INDEX*CDB_PORTS-1:0] r_cdb_index;

    logic [FU_NUM-1:0]             w_elig;
    logic [FU_NUM-1:0]             w_pick_grant;
    logic [CDB_PORTS-1:0][PW-1:0]  w_slot_fu;
    logic [CDB_PORTS-1:0]          w_slot_vld;
    logic [PW-1:0]                 w_last_fu;
    logic                          w_any;
    logic [PW-1:0]                 w_ptr_next;

    // A NULL-tagged request is treated as if it were not there at all.
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < FU_NUM; i++) begin
            w_elig[i] = fu_req[i] && (fu_index[i*RB_INDEX +: RB_INDEX] != RB_NULL);
        end
    end

    cdb_rr_picker #(
        .N  (FU_NUM),
        .P  (CDB_PORTS),
        .PW (PW)
    ) u_picker (
        .i_elig     (w_elig),
        .i_start    (r_rr_ptr),
        .o_grant    (w_pick_grant),
        .o_slot_fu  (w_slot_fu),
        .o_slot_vld (w_slot_vld),
        .o_last_fu  (w_last_fu),
        .o_any      (w_any)
    );

    assign fu_grant   = (reset || flush) ? '0 : w_pick_grant;
    assign w_ptr_next = (w_last_fu == PW'(FU_NUM - 1)) ? '0 : w_last_fu + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_ptr    <= '0;
            r_cdb_valid <= '0;
            r_cdb_data  <= '0;
            r_cdb_index <= {CDB_PORTS{RB_NULL}};
        end else if (flush) begin
            r_cdb_valid <= '0;
            r_cdb_index <= {CDB_PORTS{RB_NULL}};
        end else begin
            for (int j = 0; j < CDB_PORTS; j++) begin
                if (w_slot_vld[j]) begin
                    r_cdb_valid[j] <= 1'b1;
                    r_cdb_data[j*WORD_SIZE +: WORD_SIZE] <=
                        fu_data[int'(w_slot_fu[j])*WORD_SIZE +: WORD_SIZE];
                    r_cdb_index[j*RB_INDEX +: RB_INDEX] <=
                        fu_index[int'(w_slot_fu[j])*RB_INDEX +: RB_INDEX];
                end else begin
                    // Data deliberately holds; only valid and index mark the slot empty.
                    r_cdb_valid[j] <= 1'b0;
                    r_cdb_index[j*RB_INDEX +: RB_INDEX] <= RB_NULL;
                end
            end
            if (w_any) r_rr_ptr <= w_ptr_next;
        end
    end

    assign cdb_valid = r_cdb_valid;
    assign cdb_data  = r_cdb_data;
    assign cdb_index = r_cdb_index;

`ifdef CDB_ARB_STATS_EN
    logic [31:0] r_stat_conflicts;
    logic [31:0] r_stat_broadcasts;
    int          w_n_elig;
    int          w_n_grant;
    logic [32:0] w_bc_sum;

    assign w_n_elig  = $countones(w_elig);
    assign w_n_grant = $countones(fu_grant);
    assign w_bc_sum  = {1'b0, r_stat_broadcasts} + 33'(w_n_grant);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stat_conflicts  <= '0;
            r_stat_broadcasts <= '0;
        end else begin
            if ((w_n_elig > CDB_PORTS) && (r_stat_conflicts != '1))
                r_stat_conflicts <= r_stat_conflicts + 32'd1;
            r_stat_broadcasts <= w_bc_sum[32] ? '1 : w_bc_sum[31:0];
        end
    end

    assign stat_conflicts  = r_stat_conflicts;
    assign stat_broadcasts = r_stat_broadcasts;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: the driver pushes expected CDB outputs, a monitor pops and compares.
// Stats counters are checked when CDB_ARB_STATS_EN is defined.
module tb_cdb_arbiter;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic [5:0]    fu_req;
    logic [191:0]  fu_data;
    logic [23:0]   fu_index;
    logic [5:0]    fu_grant;
    logic [1:0]    cdb_valid;
    logic [63:0]   cdb_data;
    logic [7:0]    cdb_index;
`ifdef CDB_ARB_STATS_EN
    logic [31:0]   stat_conflicts;
    logic [31:0]   stat_broadcasts;
`endif

    localparam logic [31:0] D0 = 32'hCAFE0000, D1 = 32'hCAFE0001, D2 = 32'hCAFE0002;
    localparam logic [31:0] D3 = 32'hCAFE0003, D4 = 32'hCAFE0004, D5 = 32'hCAFE0005;

    cdb_arbiter #(
        .FU_NUM(6), .CDB_PORTS(2), .WORD_SIZE(32), .RB_INDEX(4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .fu_req    (fu_req),
        .fu_data   (fu_data),
        .fu_index  (fu_index),
        .fu_grant  (fu_grant),
        .cdb_valid (cdb_valid),
        .cdb_data  (cdb_data),
        .cdb_index (cdb_index)
`ifdef CDB_ARB_STATS_EN
        ,
        .stat_conflicts  (stat_conflicts),
        .stat_broadcasts (stat_broadcasts)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  v;
        logic [7:0]  idx;
        logic [63:0] d;
    } exp_t;

    exp_t exp_q[$];
    exp_t e_mon;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Called just after a negedge: drive, check the combinational grant, queue the broadcast.
    task automatic step(input logic [5:0] req, input logic fl, input logic [5:0] eg,
                        input logic [1:0] ev, input logic [7:0] ei, input logic [63:0] ed);
        exp_t e;
        fu_req = req;
        flush  = fl;
        #1;
        chk("fu_grant", 64'(fu_grant), 64'(eg));
        e.v = ev; e.idx = ei; e.d = ed;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            e_mon = exp_q.pop_front();
            chk("cdb_valid", 64'(cdb_valid), 64'(e_mon.v));
            chk("cdb_index", 64'(cdb_index), 64'(e_mon.idx));
            chk("cdb_data",  cdb_data,       e_mon.d);
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset    = 1'b1;
        flush    = 1'b0;
        fu_req   = 6'b111111;
        fu_index = {4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
        fu_data  = {D5, D4, D3, D2, D1, D0};
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", 64'(cdb_valid), 64'(2'b00));
        chk("rst_index", 64'(cdb_index), 64'(8'hFF));
        chk("rst_data",  cdb_data, 64'h0);
        chk("rst_grant", 64'(fu_grant), 64'(6'b0));
        reset = 1'b0;

        // Four eligible requests for three cycles (FUs drop after their transfer)
        step(6'b001111, 1'b0, 6'b000011, 2'b11, 8'h10, {D1, D0});
        step(6'b111100, 1'b0, 6'b001100, 2'b11, 8'h32, {D3, D2});
        step(6'b110011, 1'b0, 6'b110000, 2'b11, 8'h54, {D5, D4});
        step(6'b000000, 1'b0, 6'b000000, 2'b00, 8'hFF, {D5, D4});
`ifdef CDB_ARB_STATS_EN
        chk("stat_conflicts",  64'(stat_conflicts),  64'd3);
        chk("stat_broadcasts", 64'(stat_broadcasts), 64'd6);
`endif

        // All six request
        step(6'b111111, 1'b0, 6'b000011, 2'b11, 8'h10, {D1, D0});
        step(6'b111100, 1'b0, 6'b001100, 2'b11, 8'h32, {D3, D2});
        step(6'b110000, 1'b0, 6'b110000, 2'b11, 8'h54, {D5, D4});
        step(6'b000000, 1'b0, 6'b000000, 2'b00, 8'hFF, {D5, D4});

        // NULL-tagged FU3 ignored, FU5 with index 7 alone
        fu_index[15:12] = 4'hF;
        fu_index[23:20] = 4'd7;
        step(6'b101000, 1'b0, 6'b100000, 2'b01, 8'hF7, {D5, D5});
        fu_index[15:12] = 4'd3;
        fu_index[23:20] = 4'd5;
        step(6'b000000, 1'b0, 6'b000000, 2'b00, 8'hFF, {D5, D5});

        // Wrap: FU4 alone leaves pointer at 5, then FU5 precedes FU0
        step(6'b010000, 1'b0, 6'b010000, 2'b01, 8'hF4, {D5, D4});
        step(6'b100001, 1'b0, 6'b100001, 2'b11, 8'h05, {D0, D5});
        step(6'b000111, 1'b0, 6'b000110, 2'b11, 8'h21, {D2, D1});
        step(6'b000001, 1'b0, 6'b000001, 2'b01, 8'hF0, {D2, D0});

        // Flush blocks grants and clears the slots; pointer unchanged
        step(6'b000110, 1'b1, 6'b000000, 2'b00, 8'hFF, {D2, D0});
        step(6'b000110, 1'b0, 6'b000110, 2'b11, 8'h21, {D2, D1});

        // Back-to-back grants of a lone requester
        step(6'b000100, 1'b0, 6'b000100, 2'b01, 8'hF2, {D2, D2});
        step(6'b000100, 1'b0, 6'b000100, 2'b01, 8'hF2, {D2, D2});

        // Reset in the middle of a broadcast
        step(6'b111111, 1'b0, 6'b011000, 2'b11, 8'h43, {D4, D3});
        reset = 1'b1;
        #1;
        chk("midrst_valid", 64'(cdb_valid), 64'(2'b00));
        chk("midrst_index", 64'(cdb_index), 64'(8'hFF));
        chk("midrst_data",  cdb_data, 64'h0);
        chk("midrst_grant", 64'(fu_grant), 64'(6'b0));
`ifdef CDB_ARB_STATS_EN
        chk("midrst_conflicts",  64'(stat_conflicts),  64'd0);
        chk("midrst_broadcasts", 64'(stat_broadcasts), 64'd0);
`endif
        @(negedge clk);
        reset = 1'b0;
        // Pointer back at 0: FU0,FU1 win over FU5
        step(6'b100011, 1'b0, 6'b000011, 2'b11, 8'h10, {D1, D0});
        step(6'b000000, 1'b0, 6'b000000, 2'b00, 8'hFF, {D1, D0});

        @(negedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
